regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-read-port register file, successor to the 32x32 two-read-port file used by the datapath.
- Adds configurable width, depth and read-port count.
- Adds write-to-read bypass, an optional registered read stage, async clear of all storage on reset, and a per-register busy scoreboard for pending writebacks.
- Sits between decode (read/issue) and writeback (write/retire) in the core pipeline.

Parameters:
XLEN, 32, data width of each register in bits
NREG, 32, number of registers (power of two, >=2); AW = clog2(NREG)
NREAD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = old value is read
READ_LAT, 0, 0 = combinational read; 1 = read data and busy registered, 1-cycle latency
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
RegWEn  in  1  write enable (writeback)
w_reg  in  AW  write address
w_data  in  XLEN  write data
r_reg  in  NREAD*AW  read addresses; port i in bits [i*AW +: AW]
r_data  out  NREAD*XLEN  read data; port i in bits [i*XLEN +: XLEN]
busy_set  in  1  issue: mark busy_reg as having a pending write
busy_reg  in  AW  register to mark busy
r_busy  out  NREAD  busy flag of the register addressed on each read port
any_busy  out  1  OR of all busy bits

Behaviour:
- Reset (async, rst=1):
  - All NREG registers clear to 0.
  - All busy bits clear to 0.
  - READ_LAT=1 output registers clear to 0: r_data=0, r_busy=0.
  - any_busy=0.
  - Reset mid-operation drops any in-flight write or busy_set in that cycle.
- Write: on posedge clk with RegWEn=1, regs[w_reg] <= w_data and busy[w_reg] <= 0.
  - With ZERO_REG=1 and w_reg=0: write ignored; register 0 always reads 0.
- Busy set: on posedge clk with busy_set=1, busy[busy_reg] <= 1.
  - With ZERO_REG=1 and busy_reg=0: ignored.
  - busy_set and RegWEn to the same register in the same cycle: set wins, final busy=1 (a new producer was issued); the data write still happens.
- Read, READ_LAT=0: combinational.
  - r_data[i] = regs[r_reg[i]].
  - If BYPASS=1, RegWEn=1, w_reg=r_reg[i] and the address is not hardwired zero, then r_data[i]=w_data instead.
  - r_busy[i] = busy[r_reg[i]], with the same bypass rule: a matching write this cycle reports 0, unless busy_set also targets that register, in which case it reports 1.
- Read, READ_LAT=1: the values above are sampled on posedge and presented the next cycle. Latency is exactly 1; no enable or stall input.
- Read ports are independent. Multiple ports may address the same register.
- any_busy is combinational from current busy state, with no bypass.
- No X propagation: out-of-range addresses cannot occur because NREG is a power of two.

Decomposition:
- Shared package regfile_pkg: default XLEN/NREG, function clog2, localparam for the zero-register index.
- Sub-module regfile_rdport: one read port, containing the address mux, the bypass compare and the optional output register.
- regfile_mp instantiates storage, the busy vector and NREAD regfile_rdport instances via generate.

Test Plan:
1. Reset clear: write 0xDEADBEEF to r5, assert rst asynchronously mid-cycle -> r_data on a port addressing r5 reads 0x0 immediately (READ_LAT=0); any_busy=0.
2. Basic write/read: write 0x12345678 to r7, then read r7 on ports 0 and 1 -> both ports 0x12345678; read r8 -> 0x0.
3. Zero register: RegWEn=1, w_reg=0, w_data=0xFFFFFFFF; busy_set on r0 -> r0 reads 0, r_busy=0, any_busy=0.
4. Bypass: r3 holds 0x11, same-cycle write r3=0x22 while reading r3.
   - BYPASS=1 -> r_data=0x22.
   - BYPASS=0 -> 0x11 this cycle, 0x22 the next.
5. Scoreboard: busy_set r9 -> r_busy=1 next cycle, any_busy=1. Write r9 -> busy clears, and r_busy reads 0 in the write cycle under bypass. Simultaneous busy_set and write to r9 -> busy remains 1.
6. READ_LAT=1: write r4=0xA5A5A5A5, then present r_reg=4 at cycle N -> r_data=0xA5A5A5A5 at cycle N+1, not at N; after reset r_data=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  // Index of the register that is hardwired to zero when ZERO_REG=1.
  localparam int ZERO_IDX = 0;

  // Ceiling log2. Used at elaboration time to size address fields.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: address mux, write-bypass compare and optional output register.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = clog2(DEF_NREG),
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREG*XLEN-1:0] regs_flat,
  input  logic [NREG-1:0]      busy,
  input  logic [AW-1:0]        r_addr,
  // we/bs arrive already qualified: a hardwired-zero target never asserts them.
  input  logic                 we,
  input  logic [AW-1:0]        w_reg,
  input  logic [XLEN-1:0]      w_data,
  input  logic                 bs,
  input  logic [AW-1:0]        busy_reg,
  output logic [XLEN-1:0]      r_data,
  output logic                 r_busy
);

  logic            wr_hit;
  logic [XLEN-1:0] word;
  logic [XLEN-1:0] comb_data;
  logic            comb_busy;
  logic [XLEN-1:0] q_data;
  logic            q_busy;

  assign word   = regs_flat[XLEN*int'(r_addr) +: XLEN];
  assign wr_hit = (BYPASS != 0) && we && (w_reg == r_addr);

  // Forward the in-flight write; a same-cycle new producer keeps the register busy.
  always_comb begin
    comb_data = word;
    comb_busy = busy[r_addr];
    if (wr_hit) begin
      comb_data = w_data;
      comb_busy = bs && (busy_reg == r_addr);
    end
  end

  // Output stage used when READ_LAT=1; pruned by synthesis otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data <= '0;
      q_busy <= 1'b0;
    end else begin
      q_data <= comb_data;
      q_busy <= comb_busy;
    end
  end

  assign r_data = (READ_LAT != 0) ? q_data : comb_data;
  assign r_busy = (READ_LAT != 0) ? q_busy : comb_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD read ports, one write port,
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWEn,
  input  logic [AW-1:0]         w_reg,
  input  logic [XLEN-1:0]       w_data,
  input  logic [NREAD*AW-1:0]   r_reg,
  output logic [NREAD*XLEN-1:0] r_data,
  input  logic                  busy_set,
  input  logic [AW-1:0]         busy_reg,
  output logic [NREAD-1:0]      r_busy,
  output logic                  any_busy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic [XLEN-1:0]      regs [NREG];
  logic [NREG-1:0]      busy;
  logic [NREG*XLEN-1:0] regs_flat;
  logic                 we_eff;
  logic                 bs_eff;

  // Writes and busy marks aimed at the hardwired zero register are dropped here,
  // so neither storage nor the read-port bypass ever sees them.
  assign we_eff = RegWEn   && !((ZERO_REG != 0) && (w_reg == ZERO_ADDR));
  assign bs_eff = busy_set && !((ZERO_REG != 0) && (busy_reg == ZERO_ADDR));

  // Register storage: async clear, single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we_eff) begin
      regs[w_reg] <= w_data;
    end
  end

  // Busy scoreboard: writeback clears, issue sets; set is applied last so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we_eff) busy[w_reg]    <= 1'b0;
      if (bs_eff) busy[busy_reg] <= 1'b1;
    end
  end

  // Flatten storage so each read port can take it as a single vector.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREG; i++) regs_flat[i*XLEN +: XLEN] = regs[i];
  end

  assign any_busy = |busy;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    regfile_rdport #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .READ_LAT (READ_LAT)
    ) u_rdport (
      .clk       (clk),
      .rst       (rst),
      .regs_flat (regs_flat),
      .busy      (busy),
      .r_addr    (r_reg[p*AW +: AW]),
      .we        (we_eff),
      .w_reg     (w_reg),
      .w_data    (w_data),
      .bs        (bs_eff),
      .busy_reg  (busy_reg),
      .r_data    (r_data[p*XLEN +: XLEN]),
      .r_busy    (r_busy[p])
    );
  end

endmodule
